// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and types for the seven-segment scan driver.
//   SEG_LUT    - active-low segment patterns for hex digits 0..F (dp bit = 1)
//   SEG_BLANK  - all segments off
//   SEG_DASH   - only segment g lit (shown for out-of-range decimal values)
//   DEC_MAX    - largest value that fits in four decimal digits
//   bcd_state_t - states of the sequential binary-to-BCD converter
package sseg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    localparam logic [15:0] DEC_MAX = 16'd9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } bcd_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
//   clk, rst - clock, asynchronous active-high reset
//   start    - begin converting bin (only honoured in IDLE)
//   bin      - 16-bit unsigned value
//   done     - one-cycle pulse while in COMMIT; bcd/ovf are valid then
//   bcd      - four BCD digits, digit 0 in [3:0]
//   ovf      - bin exceeded 9999 (bcd is then meaningless)
// Takes 16 SHIFT cycles followed by one COMMIT cycle.
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    bcd_state_t  state, next_state;
    logic [15:0] bin_sr;
    logic [15:0] bcd_sr;
    logic [4:0]  iter;

    // Add 3 to every BCD nibble that is 5 or more, so the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (iter == 5'd15) next_state = COMMIT;
            COMMIT: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            iter   <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bin_sr <= bin;
                    bcd_sr <= '0;
                    iter   <= '0;
                    ovf    <= (bin > DEC_MAX);
                end
                SHIFT: begin
                    {bcd_sr, bin_sr} <= {dabble_adjust(bcd_sr), bin_sr} << 1;
                    iter             <= iter + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bcd = bcd_sr;

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed four-digit seven-segment driver.
//   clk, rst  - clock, asynchronous active-high reset
//   data_in   - 16-bit value to display
//   load      - one-cycle capture strobe for data_in and dec_mode
//   dec_mode  - 1: unsigned decimal (leading zeros blanked, dashes if >9999)
//               0: hexadecimal
//   busy      - decimal conversion running; loads are ignored meanwhile
//   segs      - active-low segments {dp, g..a}, dp always off
//   an        - active-low digit enables, an[0] = rightmost digit
// Each digit is lit for REFRESH_DIV cycles; scanning never pauses.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        dec_mode,
    output logic        busy,
    output logic [7:0]  segs,
    output logic [3:0]  an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;

    logic [3:0][3:0]  digits;
    logic [3:0]       blank;
    logic             dash;

    logic             accept, conv_start, hex_load;
    logic             conv_done, conv_ovf;
    logic [15:0]      conv_bcd;
    logic [3:0]       dec_blank;

    logic [7:0]       segs_next;
    logic [3:0]       an_next;

    assign accept     = load & ~busy;
    assign conv_start = accept & dec_mode;
    assign hex_load   = accept & ~dec_mode;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (data_in),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // busy covers SHIFT and COMMIT, so a load on the commit edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= 1'b0;
        else if (conv_start)
            busy <= 1'b1;
        else if (conv_done)
            busy <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Leading-zero blanking: a digit is dark only if it and every digit to
    // its left are zero. Digit 0 always shows.
    always_comb begin
        dec_blank    = 4'b0000;
        dec_blank[3] = (conv_bcd[15:12] == 4'd0);
        dec_blank[2] = dec_blank[3] & (conv_bcd[11:8] == 4'd0);
        dec_blank[1] = dec_blank[2] & (conv_bcd[7:4] == 4'd0);
    end

    // NOTE: the display registers are few and must start dark, so all of
    // them are reset explicitly rather than left to power-up contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= '0;
            blank  <= 4'hF;
            dash   <= 1'b0;
        end else if (hex_load) begin
            digits <= data_in;
            blank  <= 4'h0;
            dash   <= 1'b0;
        end else if (conv_done) begin
            digits <= conv_bcd;
            dash   <= conv_ovf;
            blank  <= conv_ovf ? 4'h0 : dec_blank;
        end
    end

    always_comb begin
        segs_next = SEG_BLANK;
        an_next   = 4'hF;
        if (!blank[digit_idx]) begin
            an_next   = ~(4'b0001 << digit_idx);
            segs_next = dash ? SEG_DASH : SEG_LUT[digits[digit_idx]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segs <= SEG_BLANK;
            an   <= 4'hF;
        end else begin
            segs <= segs_next;
            an   <= an_next;
        end
    end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Time-multiplexed four-digit seven-segment display driver for the OTTER wrapper's `segs`/`an` outputs. It drives the physical display that the board and the wrapper bench observe. It captures a 16-bit value from the MMIO output register, shows it in hex, or in decimal via an internal sequential binary-to-BCD converter, and scans the four digits at a fixed refresh rate.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clk cycles each digit stays lit. Must be ≥ 2.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `data_in`  in  16: value to display.
- `load`  in  1: single-cycle capture strobe for `data_in` and `dec_mode`.
- `dec_mode`  in  1: 1 selects unsigned decimal display; 0 selects hex display.
- `busy`  out  1: decimal conversion in progress. A `load` is ignored while `busy` is high.
- `segs`  out  8: active-low segments. Bits [6:0] are g..a; bit 7 is dp and is always 1.
- `an`  out  4: active-low digit enables, at most one low. `an[0]` is the rightmost digit.

## Operation
- **Display registers:** four 4-bit digit codes plus a per-digit blank flag and a global dash flag. They update atomically, only at commit.
- **Hex mode:** on `load`, digit i is set to `data_in[4i+3:4i]`. Commit happens on the same edge. No blanking.
- **Decimal mode:** on `load`, `bin2bcd_seq` starts.
  - The FSM has states IDLE → SHIFT (16 cycles, add-3-then-shift double-dabble) → COMMIT → IDLE.
  - If `data_in` > 9999, all four digits show a dash (`segs` = 8'hBF).
  - Otherwise, leading zeros in digits 3..1 are blanked. Digit 0 is always shown.
- **Scan:**
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - Scanning never stops, including during conversion; the old value stays visible.
- **Output for the current index:**
  - Blank digit: `an` = 4'hF and `segs` = 8'hFF.
  - Otherwise: the `an` bit for the index is low and `segs` = the encoded digit.
- **Encoding (active low, dp=1):** 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- **Reset state:** `segs` = 8'hFF, `an` = 4'hF, `busy` = 0, digit index 0, refresh counter 0, FSM IDLE. All blank flags are set, so the display is dark until the first `load`.
- **Reset mid-conversion:** the conversion aborts, the result is discarded, and the reset state applies.
- **`load` while busy:** ignored. No queueing.
- **`load` in the commit cycle:** busy is still high, so it is ignored.

## Timing
- `segs`/`an` are registered and reflect the display registers and index one cycle after either changes.
- **Hex latency:** `load` sampled at edge t → display registers updated at t → outputs valid after edge t+1 if that digit is currently scanned.
- **Decimal latency:**
  - `load` at edge t → `busy` high from after edge t.
  - SHIFT occupies edges t+1..t+16; COMMIT at edge t+17, which updates the display registers and drops `busy`.
  - Outputs reflect the new value after edge t+18.
- **Digit dwell:** exactly REFRESH_DIV cycles per digit; full frame = 4·REFRESH_DIV cycles.
- **Simultaneous refresh wrap and commit:** the new index and the new digit data both appear in the same registered output update.

## Structure
- `sseg_pkg` holds:
  - the 16-entry segment encoding constant array;
  - `SEG_BLANK` = 8'hFF and `SEG_DASH` = 8'hBF;
  - the FSM state typedef (IDLE, SHIFT, COMMIT).
- Sub-module `bin2bcd_seq` holds the double-dabble shift/adjust datapath and the 5-bit iteration counter. Its interface is `start`, `bin[15:0]`, `done`, `bcd[15:0]`, `ovf`.
- The top level holds the refresh counter, digit index, display registers, output muxing and registers.

## Test plan
Use `REFRESH_DIV` = 4 for all scenarios.
- **Reset:** assert `rst` mid-frame → `segs` = 8'hFF and `an` = 4'hF immediately (async), and they stay so until the first `load`.
- **Hex frame:** `load` 0x1234 with `dec_mode` = 0 → over one 16-cycle frame, observe (`an`, `segs`) = (E, 99), (D, B0), (B, A4), (7, F9), each held 4 cycles.
- **Decimal 42:** `load` 42 with `dec_mode` = 1 → `busy` high for 17 cycles.
  - Then `an[0]` shows A4 and `an[1]` shows 99.
  - Digits 2 and 3 are dark (`an` = F, `segs` = FF) during their slots.
- **Decimal overflow:** `load` 10000 in decimal mode → after commit, all four digits show BF.
  - `load` 9999 → each digit shows 90.
  - `load` 0 → only digit 0 is lit, showing C0.
- **Load while busy:** `load` 0x0005 (decimal), then `load` 0xFFFF (hex) 3 cycles later → the second load is ignored and the display shows the single digit 92.
- **Reset mid-conversion:** start a decimal `load` of 1234, assert `rst` at SHIFT cycle 8 → `busy` = 0, display dark; the next hex `load` of 0x00AB displays normally.
